// File: rtl/riscv_pkg.sv
// Shared load/store decode definitions for the data-memory stage.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'd0,
    ACC_HALF = 2'd1,
    ACC_WORD = 2'd2,
    ACC_NONE = 2'd3
  } acc_size_e;

  // Access size of a funct3 code; ACC_NONE marks a code that is illegal for
  // the given direction (unsigned variants exist only for loads).
  function automatic acc_size_e decode_size(input logic [2:0] f3, input logic is_store);
    acc_size_e sz;
    sz = ACC_NONE;
    case (f3)
      F3_LB:   sz = ACC_BYTE;
      F3_LH:   sz = ACC_HALF;
      F3_LW:   sz = ACC_WORD;
      F3_LBU:  if (!is_store) sz = ACC_BYTE;
      F3_LHU:  if (!is_store) sz = ACC_HALF;
      default: sz = ACC_NONE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM with per-byte write enables and a registered read port.
module dmem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          rd_en,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Synchronous read, only when a load is accepted so rdata stays stable otherwise.
  always_ff @(posedge clk) begin
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_stage.sv
// MEM-stage data memory access: store lane steering, fault detection,
// load alignment/extension into a registered WB result, and access counters.
module dmem_stage
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite_M,
  input  logic        MemRead_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] WriteData_M,
  output logic [31:0] ReadData_W,
  output logic        MisalignErr,
  output logic [15:0] LoadCount,
  output logic [15:0] StoreCount
);

  localparam int AW = $clog2(DEPTH_WORDS);

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Shift the addressed byte/half down to bit 0 and extend per funct3.
  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (decode_size(f3, 1'b0))
      ACC_BYTE: res = f3[2] ? {24'h0, sh[7:0]}  : 32'($signed(sh[7:0]));
      ACC_HALF: res = f3[2] ? {16'h0, sh[15:0]} : 32'($signed(sh[15:0]));
      ACC_WORD: res = sh;
      default:  res = 32'h0;
    endcase
    return res;
  endfunction

  // ---- stage p0: request decode on the live MEM-stage inputs ----
  logic [AW-1:0] word_idx_p0;
  logic [1:0]    off_p0;
  acc_size_e     size_p0;
  logic          req_p0, both_p0, fault_p0, st_ok_p0, ld_ok_p0;
  logic [3:0]    be_p0;
  logic [31:0]   wdata_p0;
  logic          unused_addr_hi;

  assign word_idx_p0    = ALUResult_M[AW+1:2];
  assign off_p0         = ALUResult_M[1:0];
  assign unused_addr_hi = ^ALUResult_M[31:AW+2];

  // Fault check and lane steering; when both strobes are set the request is a store.
  always_comb begin
    req_p0   = MemWrite_M | MemRead_M;
    both_p0  = MemWrite_M & MemRead_M;
    size_p0  = decode_size(funct3_M, MemWrite_M);
    fault_p0 = 1'b0;
    be_p0    = 4'b0000;
    wdata_p0 = WriteData_M;
    case (size_p0)
      ACC_BYTE: begin
        be_p0    = 4'b0001 << off_p0;
        wdata_p0 = {4{WriteData_M[7:0]}};
      end
      ACC_HALF: begin
        fault_p0 = off_p0[0];
        be_p0    = off_p0[1] ? 4'b1100 : 4'b0011;
        wdata_p0 = {2{WriteData_M[15:0]}};
      end
      ACC_WORD: begin
        fault_p0 = (off_p0 != 2'b00);
        be_p0    = 4'b1111;
      end
      default: fault_p0 = 1'b1;
    endcase
    fault_p0 = req_p0 & fault_p0;
    st_ok_p0 = MemWrite_M & ~fault_p0;
    ld_ok_p0 = MemRead_M & ~MemWrite_M & ~fault_p0;
    if (!st_ok_p0) be_p0 = 4'b0000;
  end

  logic [31:0] rdata_p1;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .be    (be_p0),
    .addr  (word_idx_p0),
    .wdata (wdata_p0),
    .rd_en (ld_ok_p0),
    .rdata (rdata_p1)
  );

  // ---- stage p1: RAM word available, registered request attributes ----
  logic       vld_p1;
  logic       zero_p1;
  logic [2:0] funct3_p1;
  logic [1:0] off_p1;

  // Control that travels with the RAM read; a reset discards any in-flight load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      zero_p1 <= 1'b0;
    end else begin
      vld_p1  <= ld_ok_p0;
      zero_p1 <= fault_p0 | both_p0;
    end
  end

  // Decode attributes captured with the request so alignment ignores later inputs.
  always_ff @(posedge clk) begin
    if (ld_ok_p0) begin
      funct3_p1 <= funct3_M;
      off_p1    <= off_p0;
    end
  end

  // WB result: zero after a fault or dual request, aligned data after a load,
  // otherwise (idle or plain store) the previous value is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadData_W <= 32'h0;
    end else if (zero_p1) begin
      ReadData_W <= 32'h0;
    end else if (vld_p1) begin
      ReadData_W <= load_align(rdata_p1, off_p1, funct3_p1);
    end
  end

  // Sticky fault flag and saturating counters of accepted accesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MisalignErr <= 1'b0;
      LoadCount   <= 16'h0;
      StoreCount  <= 16'h0;
    end else begin
      if (fault_p0) MisalignErr <= 1'b1;
      if (ld_ok_p0) LoadCount  <= sat_inc(LoadCount);
      if (st_ok_p0) StoreCount <= sat_inc(StoreCount);
    end
  end

endmodule

// File: tb/tb_dmem_stage.sv
// Bench for dmem_stage: byte-level reference model plus directed vectors.
module tb_dmem_stage;

  localparam int DEPTH = 256;
  localparam int MEMB  = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite_M = 1'b0;
  logic        MemRead_M = 1'b0;
  logic [2:0]  funct3_M = 3'b000;
  logic [31:0] ALUResult_M = 32'h0;
  logic [31:0] WriteData_M = 32'h0;
  logic [31:0] ReadData_W;
  logic        MisalignErr;
  logic [15:0] LoadCount;
  logic [15:0] StoreCount;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  dmem_stage #(.DEPTH_WORDS(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite_M  (MemWrite_M),
    .MemRead_M   (MemRead_M),
    .funct3_M    (funct3_M),
    .ALUResult_M (ALUResult_M),
    .WriteData_M (WriteData_M),
    .ReadData_W  (ReadData_W),
    .MisalignErr (MisalignErr),
    .LoadCount   (LoadCount),
    .StoreCount  (StoreCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mbytes [MEMB];
  logic [31:0] exp_rd = 32'h0;
  logic        exp_err = 1'b0;
  logic [15:0] exp_lc = 16'h0;
  logic [15:0] exp_sc = 16'h0;
  int          pend = 0;        // 0 none, 1 zero result, 2 load result
  logic [31:0] pend_val = 32'h0;

  // Bytes touched by a funct3 code; 0 for a code illegal in that direction.
  function automatic int m_size(input bit st, input logic [2:0] f3);
    case (f3)
      3'b000: return 1;
      3'b001: return 2;
      3'b010: return 4;
      3'b100: return st ? 0 : 1;
      3'b101: return st ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = m_size(st, f3);
    if (n == 0) return 1'b1;
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic int m_base(input logic [31:0] a);
    return int'(a % 32'(MEMB));
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = m_size(1'b0, f3);
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mbytes[m_base(a) + i];
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  function automatic logic [15:0] m_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_rd  <= 32'h0;
      exp_err <= 1'b0;
      exp_lc  <= 16'h0;
      exp_sc  <= 16'h0;
      pend    <= 0;
    end else begin
      if (pend == 1) exp_rd <= 32'h0;
      else if (pend == 2) exp_rd <= pend_val;
      pend <= 0;
      if (MemWrite_M || MemRead_M) begin
        if (m_fault(MemWrite_M, funct3_M, ALUResult_M)) begin
          exp_err <= 1'b1;
          pend    <= 1;
        end else if (MemWrite_M) begin
          exp_sc <= m_inc(exp_sc);
          for (int i = 0; i < m_size(1'b1, funct3_M); i++)
            mbytes[m_base(ALUResult_M) + i] <= WriteData_M[8*i +: 8];
          if (MemRead_M) pend <= 1;
        end else begin
          exp_lc   <= m_inc(exp_lc);
          pend     <= 2;
          pend_val <= m_load(funct3_M, ALUResult_M);
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rd",  ReadData_W,  exp_rd);
      chk("model_err", 32'(MisalignErr), 32'(exp_err));
      chk("model_lc",  32'(LoadCount),   32'(exp_lc));
      chk("model_sc",  32'(StoreCount),  32'(exp_sc));
    end
  end

  // ---------------- stimulus ----------------
  task automatic req(input logic we, input logic re, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd);
    MemWrite_M = we; MemRead_M = re; funct3_M = f3; ALUResult_M = a; WriteData_M = wd;
    @(posedge clk); #1;
    MemWrite_M = 1'b0; MemRead_M = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    for (int i = 0; i < MEMB; i++) mbytes[i] = 8'h00;
    #1 reset = 1'b0;
    #2;
    chk("reset_rd",  ReadData_W, 32'h0);
    chk("reset_err", 32'(MisalignErr), 32'h0);
    chk("reset_lc",  32'(LoadCount), 32'h0);
    chk("reset_sc",  32'(StoreCount), 32'h0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // word store then load
    req(1, 0, 3'b010, 32'h10, 32'h12345678);
    req(0, 1, 3'b010, 32'h10, 32'h0);
    idle(1);
    chk("sw_lw_rd", ReadData_W, 32'h12345678);
    chk("sw_lw_lc", 32'(LoadCount), 32'd1);
    chk("sw_lw_sc", 32'(StoreCount), 32'd1);

    // byte store, signed/unsigned byte loads, merged word
    req(1, 0, 3'b000, 32'h13, 32'h00000080);
    req(0, 1, 3'b000, 32'h13, 32'h0);
    idle(1);
    chk("lb_rd", ReadData_W, 32'hFFFFFF80);
    req(0, 1, 3'b100, 32'h13, 32'h0);
    idle(1);
    chk("lbu_rd", ReadData_W, 32'h00000080);
    req(0, 1, 3'b010, 32'h10, 32'h0);
    idle(1);
    chk("lw_merge_rd", ReadData_W, 32'h80345678);

    // half-word lanes
    req(1, 0, 3'b010, 32'h14, 32'h11223344);
    req(1, 0, 3'b001, 32'h16, 32'h0000BEEF);
    req(0, 1, 3'b001, 32'h16, 32'h0);
    req(0, 1, 3'b101, 32'h16, 32'h0);
    chk("lh_rd", ReadData_W, 32'hFFFFBEEF);
    idle(1);
    chk("lhu_rd", ReadData_W, 32'h0000BEEF);
    req(0, 1, 3'b010, 32'h14, 32'h0);
    idle(1);
    chk("lw_half_rd", ReadData_W, 32'hBEEF3344);

    // faults: misaligned half load, misaligned word store, bad funct3
    req(0, 1, 3'b001, 32'h11, 32'h0);
    idle(1);
    chk("lh_mis_rd", ReadData_W, 32'h0);
    chk("lh_mis_err", 32'(MisalignErr), 32'h1);
    req(1, 0, 3'b010, 32'h11, 32'hFFFFFFFF);
    req(1, 0, 3'b100, 32'h10, 32'hFFFFFFFF);
    req(0, 1, 3'b011, 32'h10, 32'h0);
    idle(1);
    chk("fault_lc", 32'(LoadCount), 32'd7);
    chk("fault_sc", 32'(StoreCount), 32'd4);
    req(0, 1, 3'b010, 32'h10, 32'h0);
    idle(1);
    chk("mem_kept_rd", ReadData_W, 32'h80345678);
    chk("err_sticky", 32'(MisalignErr), 32'h1);

    // address wrap
    req(1, 0, 3'b010, 32'(MEMB), 32'hA5A5A5A5);
    req(0, 1, 3'b010, 32'h0, 32'h0);
    idle(1);
    chk("wrap_rd", ReadData_W, 32'hA5A5A5A5);

    // simultaneous read and write
    req(1, 1, 3'b010, 32'h20, 32'hDEADBEEF);
    idle(1);
    chk("both_rd", ReadData_W, 32'h0);
    req(0, 1, 3'b010, 32'h20, 32'h0);
    idle(3);
    chk("both_later_rd", ReadData_W, 32'hDEADBEEF);

    // reset with a load in flight
    req(0, 1, 3'b010, 32'h10, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_async_rd",  ReadData_W, 32'h0);
    chk("rst_async_err", 32'(MisalignErr), 32'h0);
    chk("rst_async_lc",  32'(LoadCount), 32'h0);
    chk("rst_async_sc",  32'(StoreCount), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(1);
    chk("rst_discard_rd", ReadData_W, 32'h0);
    req(0, 1, 3'b010, 32'h10, 32'h0);
    req(0, 1, 3'b010, 32'h20, 32'h0);
    chk("post_rst_rd1", ReadData_W, 32'h80345678);
    idle(1);
    chk("post_rst_rd2", ReadData_W, 32'hDEADBEEF);
    chk("post_rst_lc", 32'(LoadCount), 32'd2);
    idle(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_stage.md
DMEM_STAGE -- requirements
Module: dmem_stage

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit data-memory words; power of two, minimum 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 MemWrite_M  input  1  store request from the MEM stage.
REQ-005 MemRead_M  input  1  load request from the MEM stage.
REQ-006 funct3_M  input  3  access size/sign code of the MEM-stage instruction.
REQ-007 ALUResult_M  input  32  byte address.
REQ-008 WriteData_M  input  32  store data, right-aligned.
REQ-009 ReadData_W  output  32  registered, aligned and extended load data for the WB stage.
REQ-010 MisalignErr  output  1  sticky fault flag.
REQ-011 LoadCount  output  16  count of completed loads.
REQ-012 StoreCount  output  16  count of completed stores.

Function
REQ-013 Word index SHALL be ALUResult_M[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-014 Stores SHALL support funct3 000 SB, 001 SH and 010 SW; byte enables SHALL come from ALUResult_M[1:0], with data shifted to the addressed lanes; the write SHALL commit on the rising edge.
REQ-015 Loads SHALL support funct3 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; the selected byte/half SHALL be shifted to bit 0, sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-016 Load latency SHALL be one cycle: request at edge N, and ReadData_W is valid after edge N+1.
REQ-017 Alignment and size decode SHALL use the address offset and funct3 registered with the request, not the current inputs.
REQ-018 A load issued the cycle after a store to the same word SHALL return the newly written data.
REQ-019 Faults:
- any half access with addr[0]=1;
- any word access with addr[1:0]!=00;
- any unlisted funct3 on an active request.
REQ-020 A faulting access SHALL suppress the write, load 32'h0 into ReadData_W and set MisalignErr; MisalignErr stays 1 until reset.
REQ-021 If MemWrite_M and MemRead_M are both 1, the store SHALL execute, the read SHALL be ignored and ReadData_W SHALL load 32'h0.
REQ-022 With no request, ReadData_W SHALL hold its previous value and memory SHALL be unchanged.
REQ-023 LoadCount/StoreCount SHALL increment by 1 per non-faulting load/store, and saturate at 16'hFFFF.

Reset
REQ-024 When reset=0, ReadData_W=0, MisalignErr=0, LoadCount=0 and StoreCount=0 immediately, with no clock required.
REQ-025 Memory contents SHALL NOT be reset; an in-flight load during reset is discarded.
REQ-026 The first request SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-027 riscv_pkg SHALL hold the funct3 load/store code localparams and the access-size enum.
REQ-028 One sub-module, dmem_ram, SHALL hold the DEPTH_WORDS x 32 byte-enable array with synchronous write and synchronous read.
REQ-029 Alignment, extension and fault logic SHALL reside in dmem_stage.

Verification
REQ-030 SW 0x12345678 @0x10, then LW @0x10 -> ReadData_W=0x12345678 one cycle after the load; LoadCount=1, StoreCount=1.
REQ-031 SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80345678.
REQ-032 LH @0x11 -> ReadData_W=0, MisalignErr=1 and stays 1; a following SW @0x11 leaves memory unchanged; counters do not increment.
REQ-033 SW 0xA5A5A5A5 @(4*DEPTH_WORDS) -> LW @0x0 returns 0xA5A5A5A5 (wrap-around).
REQ-034 Set MemWrite_M=MemRead_M=1, SW 0xDEADBEEF @0x20 -> ReadData_W=0; a later LW @0x20 returns 0xDEADBEEF.
REQ-035 Assert reset mid-load -> ReadData_W=0 and flags/counters=0 asynchronously; memory still holds pre-reset data.
